// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low digit patterns
// and the idle anode/cathode levels.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef logic [2:0] idx_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_DIGITS[0];
      4'd1:    seg = SEG_DIGITS[1];
      4'd2:    seg = SEG_DIGITS[2];
      4'd3:    seg = SEG_DIGITS[3];
      4'd4:    seg = SEG_DIGITS[4];
      4'd5:    seg = SEG_DIGITS[5];
      4'd6:    seg = SEG_DIGITS[6];
      4'd7:    seg = SEG_DIGITS[7];
      4'd8:    seg = SEG_DIGITS[8];
      4'd9:    seg = SEG_DIGITS[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver. Inputs are snapshotted once per
// frame so a refreshing display never tears between two values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic [3:0] bcd5,
  input  logic [3:0] bcd6,
  input  logic [3:0] bcd7,
  input  logic [7:0] dp_in,
  input  logic [7:0] digit_en,
  input  logic       blank_lz,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int             CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0]     cnt_r;
  idx_t              idx_r;
  logic              tick_s;
  logic              snap_s;
  logic [7:0][3:0]   bcd_s;
  logic [7:0][3:0]   sh_bcd_r;
  logic [7:0]        sh_dp_r;
  logic [7:0]        sh_en_r;
  logic              sh_blz_r;
  logic [7:0]        lz_s;
  logic              zero_run_s;
  logic              visible_s;
  logic [6:0]        dec_seg_s;
  logic [7:0]        an_r;
  logic [6:0]        seg_r;
  logic              dp_r;
  logic              frame_tick_r;

  assign bcd_s  = {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
  assign tick_s = (cnt_r == CNT_MAX);
  assign snap_s = tick_s && (idx_r == 3'd7);

  // prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 3'd0;
    end else begin
      if (tick_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // frame snapshot of all display inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_bcd_r     <= '0;
      sh_dp_r      <= 8'h00;
      sh_en_r      <= 8'h00;
      sh_blz_r     <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= snap_s;
      if (snap_s) begin
        sh_bcd_r <= bcd_s;
        sh_dp_r  <= dp_in;
        sh_en_r  <= digit_en;
        sh_blz_r <= blank_lz;
      end
    end
  end

  // leading-zero mask: digit k blanks when it and every digit above it are zero
  always_comb begin
    lz_s       = 8'h00;
    zero_run_s = sh_blz_r;
    for (int k = 7; k >= 1; k--) begin
      zero_run_s = zero_run_s && (sh_bcd_r[k] == 4'd0);
      lz_s[k]    = zero_run_s;
    end
  end

  // current slot visibility
  always_comb begin
    if (sh_en_r[idx_r] && !lz_s[idx_r]) begin
      visible_s = 1'b1;
    end else begin
      visible_s = 1'b0;
    end
  end

  seg7_decode u_decode (
    .bcd (sh_bcd_r[idx_r]),
    .seg (dec_seg_s)
  );

  // registered pin drivers; only one anode can ever be low
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      if (visible_s) begin
        an_r  <= ~(8'h01 << idx_r);
        seg_r <= dec_seg_s;
        dp_r  <= ~sh_dp_r[idx_r];
      end else begin
        an_r  <= AN_OFF;
        seg_r <= SEG_BLANK;
        dp_r  <= 1'b1;
      end
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_tick = frame_tick_r;

endmodule
